// File: rtl/onecount_seq.sv
// Multi-cycle population counter: SLICE bits per clock, valid/ready on both
// sides, held result plus a saturating running total of delivered counts.
module onecount_seq #(
  parameter int WIDTH   = 16,
  parameter int SLICE   = 4,
  parameter int TOTAL_W = 16,
  localparam int N  = WIDTH / SLICE,
  localparam int CW = $clog2(WIDTH + 1),
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CW-1:0]      count,
  input  logic               clear,
  output logic [TOTAL_W-1:0] total
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   sreg, sreg_sh;
  logic [CW-1:0]      acc, slice_pop, acc_sum;
  logic [IW-1:0]      idx;
  logic               last;
  logic [TOTAL_W:0]   tot_sum;
  logic [TOTAL_W-1:0] tot_sat;

  // A full-width slice leaves nothing to shift in; avoid an out-of-range part select.
  generate
    if (SLICE < WIDTH) begin : g_shift
      assign sreg_sh = {{SLICE{1'b0}}, sreg[WIDTH-1:SLICE]};
    end else begin : g_noshift
      assign sreg_sh = '0;
    end
  endgenerate

  always_comb begin
    slice_pop = '0;
    for (int i = 0; i < SLICE; i++) slice_pop = slice_pop + CW'(sreg[i]);
  end

  assign acc_sum = acc + slice_pop;
  assign last    = (idx == IW'(N - 1));
  assign tot_sum = {1'b0, total} + (TOTAL_W + 1)'(count);
  assign tot_sat = tot_sum[TOTAL_W] ? {TOTAL_W{1'b1}} : tot_sum[TOTAL_W-1:0];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = BUSY;
      BUSY:    if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg  <= '0;
      acc   <= '0;
      idx   <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sreg <= mode ? ~data : data;
          acc  <= '0;
          idx  <= '0;
        end
        BUSY: begin
          acc  <= acc_sum;
          sreg <= sreg_sh;
          idx  <= idx + 1'b1;
          if (last) count <= acc_sum;
        end
        default: ;
      endcase
    end
  end

  // Clear takes priority over a same-cycle delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           total <= '0;
    else if (clear)                       total <= '0;
    else if (state == DONE && out_ready)  total <= tot_sat;
  end

endmodule

// File: tb/tb_onecount_seq.sv
// Self-checking bench for onecount_seq: default config, a narrow-total config
// for saturation, and two WIDTH=8 configs for slice-width sweep.
module tb_onecount_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;
  int exp_total = 0;

  // default instance
  logic        in_valid = 0, mode = 0, out_ready = 0, clear = 0;
  logic [15:0] data = '0;
  logic        in_ready, out_valid;
  logic [4:0]  count;
  logic [15:0] total;

  onecount_seq u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data(data), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .clear(clear), .total(total));

  // narrow total instance
  logic        s_in_valid = 0, s_out_ready = 0, s_clear = 0;
  logic [15:0] s_data = '0;
  logic        s_in_ready, s_out_valid;
  logic [4:0]  s_count;
  logic [4:0]  s_total;

  onecount_seq #(.WIDTH(16), .SLICE(4), .TOTAL_W(5)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .data(s_data), .mode(1'b0), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .count(s_count), .clear(s_clear), .total(s_total));

  // WIDTH=8 sweep: SLICE=8 and SLICE=1 share inputs
  logic       w_in_valid = 0, w_mode = 0;
  logic [7:0] w_data = '0;
  logic       wa_in_ready, wa_out_valid, wb_in_ready, wb_out_valid;
  logic [3:0] wa_count, wb_count;
  logic [7:0] wa_total, wb_total;

  onecount_seq #(.WIDTH(8), .SLICE(8), .TOTAL_W(8)) u_w8a (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(wa_in_ready),
    .data(w_data), .mode(w_mode), .out_valid(wa_out_valid), .out_ready(1'b1),
    .count(wa_count), .clear(1'b0), .total(wa_total));

  onecount_seq #(.WIDTH(8), .SLICE(1), .TOTAL_W(8)) u_w8b (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(wb_in_ready),
    .data(w_data), .mode(w_mode), .out_valid(wb_out_valid), .out_ready(1'b1),
    .count(wb_count), .clear(1'b0), .total(wb_total));

  function automatic int ref_count(input logic [15:0] d, input logic m);
    int c = 0;
    for (int i = 0; i < 16; i++) if (d[i] != m) c++;
    return c;
  endfunction

  function automatic int sat_add(input int t, input int c, input int w);
    int mx = (1 << w) - 1;
    return (t + c > mx) ? mx : t + c;
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // One word through the default instance: hold = cycles of backpressure in DONE.
  task automatic run_word(input logic [15:0] d, input logic m, input int hold,
                          input logic clr, input string tag);
    int lat, exp_c, w;
    exp_c = ref_count(d, m);
    w = 0;
    while (!in_ready && w < 64) begin tick(); w++; end
    nchk++;
    if (!in_ready) begin nerr++; $display("FAIL %s in_ready timeout", tag); end
    in_valid = 1; data = d; mode = m;
    tick();
    in_valid = 0; data = 16'($urandom); mode = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 64) begin
      nchk++;
      if (in_ready !== 1'b0) begin nerr++; $display("FAIL %s in_ready busy got=%0b want=0", tag, in_ready); end
      tick(); lat++;
    end
    nchk++;
    if (lat != 4) begin nerr++; $display("FAIL %s latency got=%0d want=4", tag, lat); end
    nchk++;
    if (count !== 5'(exp_c)) begin nerr++; $display("FAIL %s count got=%0d want=%0d", tag, count, exp_c); end
    for (int i = 0; i < hold; i++) begin
      nchk++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || count !== 5'(exp_c) || total !== 16'(exp_total)) begin
        nerr++;
        $display("FAIL %s hold%0d ov=%0b ir=%0b count=%0d total=%0d want 1/0/%0d/%0d",
                 tag, i, out_valid, in_ready, count, total, exp_c, exp_total);
      end
      if (i == 2) begin in_valid = 1; data = 16'($urandom); end
      tick();
      in_valid = 0;
    end
    out_ready = 1; clear = clr;
    tick();
    out_ready = 0; clear = 0;
    exp_total = clr ? 0 : sat_add(exp_total, exp_c, 16);
    nchk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || total !== 16'(exp_total)) begin
      nerr++;
      $display("FAIL %s post ir=%0b ov=%0b total=%0d want 1/0/%0d", tag, in_ready, out_valid, total, exp_total);
    end
  endtask

  task automatic test_reset;
    #3;
    nchk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 5'd0 || total !== 16'd0) begin
      nerr++;
      $display("FAIL reset ir=%0b ov=%0b count=%0d total=%0d", in_ready, out_valid, count, total);
    end
    #14 rst_n = 1;
    tick();
  endtask

  task automatic test_ones;
    run_word(16'hFFFF, 1'b0, 0, 1'b0, "ones");
  endtask

  task automatic test_modes;
    clear = 1; tick(); clear = 0;
    exp_total = 0;
    nchk++;
    if (total !== 16'd0) begin nerr++; $display("FAIL clear_idle total=%0d want=0", total); end
    run_word(16'h00F0, 1'b1, 0, 1'b0, "mode_zeros");
    run_word(16'hA5A5, 1'b0, 0, 1'b0, "mode_ones");
    nchk++;
    if (total !== 16'd20) begin nerr++; $display("FAIL modes total=%0d want=20", total); end
  endtask

  task automatic test_backpressure;
    run_word(16'h0001, 1'b0, 5, 1'b0, "backpressure");
    tick();
    nchk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      nerr++; $display("FAIL bp_no_accept ov=%0b ir=%0b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 20; k++)
      run_word(16'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
               ($urandom_range(0, 5) == 0), "random");
  endtask

  task automatic test_reset_mid;
    int w = 0;
    int seen = 0;
    while (!in_ready && w < 64) begin tick(); w++; end
    in_valid = 1; data = 16'hFFFF; mode = 0;
    tick();
    in_valid = 0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 0;
    #1;
    nchk++;
    if (count !== 5'd0 || total !== 16'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL reset_mid count=%0d total=%0d ov=%0b ir=%0b want 0/0/0/1", count, total, out_valid, in_ready);
    end
    #4 rst_n = 1;
    exp_total = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (out_valid) seen++; end
    nchk++;
    if (seen != 0) begin nerr++; $display("FAIL reset_mid ghost out_valid cycles=%0d want=0", seen); end
    run_word(16'h0003, 1'b0, 0, 1'b0, "after_reset");
  endtask

  task automatic s_word(input logic clr, input int exp_t);
    int w = 0;
    while (!s_in_ready && w < 64) begin tick(); w++; end
    s_in_valid = 1; s_data = 16'hFFFF;
    tick();
    s_in_valid = 0;
    w = 0;
    while (!s_out_valid && w < 64) begin tick(); w++; end
    nchk++;
    if (s_count !== 5'd16 || !s_out_valid) begin
      nerr++; $display("FAIL sat count=%0d ov=%0b want=16/1", s_count, s_out_valid);
    end
    s_out_ready = 1; s_clear = clr;
    tick();
    s_out_ready = 0; s_clear = 0;
    nchk++;
    if (s_total !== 5'(exp_t)) begin nerr++; $display("FAIL sat total got=%0d want=%0d", s_total, exp_t); end
  endtask

  task automatic test_saturate;
    int t = 0;
    for (int k = 0; k < 4; k++) begin
      t = sat_add(t, 16, 5);
      s_word(1'b0, t);
    end
    s_word(1'b1, 0);
    s_clear = 1; tick(); s_clear = 0;
    nchk++;
    if (s_total !== 5'd0) begin nerr++; $display("FAIL sat clear_alone total=%0d want=0", s_total); end
  endtask

  task automatic sweep_word(input logic [7:0] d, input logic m);
    int la = -1, lb = -1, w = 0, exp_c = 0;
    logic [3:0] ca = '0, cb = '0;
    for (int i = 0; i < 8; i++) if (d[i] != m) exp_c++;
    while (!(wa_in_ready && wb_in_ready) && w < 64) begin tick(); w++; end
    w_in_valid = 1; w_data = d; w_mode = m;
    tick();
    w_in_valid = 0; w_data = 8'($urandom); w_mode = ~m;
    for (int c = 1; c <= 20 && (la < 0 || lb < 0); c++) begin
      if (wa_out_valid && la < 0) begin la = c - 1; ca = wa_count; end
      if (wb_out_valid && lb < 0) begin lb = c - 1; cb = wb_count; end
      tick();
    end
    nchk++;
    if (la != 1 || ca !== 4'(exp_c)) begin
      nerr++; $display("FAIL sweep_s8 d=%h lat=%0d count=%0d want 1/%0d", d, la, ca, exp_c);
    end
    nchk++;
    if (lb != 8 || cb !== 4'(exp_c)) begin
      nerr++; $display("FAIL sweep_s1 d=%h lat=%0d count=%0d want 8/%0d", d, lb, cb, exp_c);
    end
  endtask

  task automatic test_sweep;
    sweep_word(8'hB7, 1'b0);
    sweep_word(8'h00, 1'b1);
    for (int k = 0; k < 4; k++) sweep_word(8'($urandom), 1'($urandom));
  endtask

  initial begin
    test_reset();
    test_ones();
    test_modes();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_saturate();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/onecount_seq.md
# onecount_seq

Parametrised, multi-cycle population counter with valid/ready handshakes on both sides. It accepts a WIDTH-bit word and counts its ones (or zeros), SLICE bits per clock. It presents the result on a held output and keeps a saturating running total across results. It sits between a word producer and a statistics consumer wherever a bit count over a wide bus is needed without a single-cycle adder tree.

## Interface

Parameters:
- WIDTH, 16, input word width; must be ≥1 and an exact multiple of SLICE.
- SLICE, 4, bits counted per clock; 1 ≤ SLICE ≤ WIDTH.
- TOTAL_W, 16, width of the running total; ≥ CW.
- Derived: N = WIDTH/SLICE (processing cycles); CW = clog2(WIDTH+1).

Ports:
- CLK, input, 1, single clock; all state changes on rising edge.
- RST_N, input, 1, asynchronous, active-low reset.
- IN_VALID, input, 1, DATA/MODE valid.
- IN_READY, output, 1, block can accept a word.
- DATA, input, WIDTH, word to count.
- MODE, input, 1, 0 = count ones, 1 = count zeros; sampled with DATA.
- OUT_VALID, output, 1, COUNT valid.
- OUT_READY, input, 1, consumer takes COUNT.
- COUNT, output, CW, result of the last accepted word.
- CLEAR, input, 1, synchronous clear of TOTAL.
- TOTAL, output, TOTAL_W, saturating sum of all delivered COUNT values.

## Operation

- FSM states are IDLE, BUSY and DONE. The reset state is IDLE.
- IDLE:
  - IN_READY = 1.
  - On IN_VALID=1, DATA is captured into a shift register. When MODE=1 the captured word is inverted (~DATA).
  - The slice index and accumulator are cleared, and the FSM goes to BUSY.
- BUSY:
  - IN_READY = 0 and OUT_VALID = 0.
  - Each cycle, the popcount of the low SLICE bits is added to the CW-bit accumulator.
  - The register then shifts right by SLICE and the slice index increments.
  - After the N-th slice, the accumulator is loaded into COUNT and the FSM goes to DONE.
- DONE:
  - OUT_VALID = 1 and IN_READY = 0.
  - COUNT is held stable until OUT_READY = 1.
  - On the handshake edge, the FSM goes to IDLE and TOTAL updates.
- Arithmetic:
  - The accumulator never overflows, because the maximum value is WIDTH < 2^CW.
  - TOTAL becomes min(TOTAL + COUNT, 2^TOTAL_W − 1), i.e. it saturates and never wraps.
- CLEAR:
  - CLEAR = 1 sets TOTAL to 0 at the next edge in any state.
  - If CLEAR and the output handshake occur in the same cycle, CLEAR wins: TOTAL = 0 and that COUNT is not added.
  - CLEAR does not affect the FSM, COUNT or the shift register.
- IN_VALID is ignored outside IDLE; an upstream word is held by its producer until IN_READY is 1.
- MODE and DATA changes after capture have no effect on the word in flight.
- Reset:
  - When RST_N is low, the FSM goes to IDLE immediately, independent of CLK.
  - COUNT = 0, TOTAL = 0 and OUT_VALID = 0; the accumulator, index and shift register are cleared.
  - IN_READY = 1 while in reset, because it is decoded from the IDLE state.
  - Any word in flight when reset asserts is discarded and no result is produced.

## Timing

- The acceptance edge is edge A (IDLE, IN_VALID = 1).
- Slices are processed on edges A+1 … A+N.
- OUT_VALID rises after edge A+N, so the latency from acceptance to OUT_VALID is N cycles.
- IN_READY falls after edge A and rises again the cycle after the output handshake edge.
- Back-to-back throughput is therefore one word per N+2 cycles when OUT_READY is held high.
- IN_READY, OUT_VALID and COUNT are pure state/register outputs, with no combinational path from any input.
- TOTAL updates on the same edge as the output handshake and is visible in the next cycle.
- Special case N = 1 (SLICE = WIDTH): BUSY lasts one cycle and OUT_VALID is high the cycle after acceptance.

## Test plan

- Defaults, MODE=0, DATA=16'hFFFF:
  - OUT_VALID is high exactly 4 cycles after acceptance.
  - COUNT = 16.
  - After the handshake, TOTAL = 16.
- MODE=1, DATA=16'h00F0, then MODE=0, DATA=16'hA5A5 with OUT_READY held high:
  - The first COUNT = 12 and the second COUNT = 8.
  - TOTAL = 20.
  - IN_READY is low from each acceptance until the cycle after its handshake.
- Backpressure, DATA=16'h0001, OUT_READY low for 5 cycles in DONE:
  - COUNT = 1 and OUT_VALID stays high throughout.
  - IN_READY stays 0 and TOTAL is unchanged until OUT_READY rises.
  - An IN_VALID pulse during this window is not accepted.
- TOTAL_W=5, four words of 16'hFFFF:
  - TOTAL goes 16, 31, 31, 31 (saturates).
  - CLEAR asserted with the fifth handshake (COUNT = 16) gives TOTAL = 0.
  - CLEAR alone on a later cycle keeps TOTAL = 0.
- Reset mid-operation, DATA=16'hFFFF accepted, RST_N pulsed low for half a cycle at A+2:
  - COUNT = 0, TOTAL = 0, OUT_VALID = 0 and IN_READY = 1 immediately.
  - No OUT_VALID pulse follows.
  - The next word, 16'h0003, yields COUNT = 2.
- Parameter sweep WIDTH=8 with SLICE=8, then SLICE=1, DATA=8'hB7:
  - COUNT = 6 in both configurations.
  - Latency is 1 cycle with SLICE=8 and 8 cycles with SLICE=1.
  - DATA=8'h00 with MODE=1 yields COUNT = 8.
